mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-into-one memory arbiter. It sits between the instruction fetch port (imem) and the write buffer's memory side (dmem) on one side, and the single shared memory/bus port on the other. It holds one request per requester, grants one transaction at a time, tags instruction fetches via mem_instr, and routes mem_ready/mem_rdata back to the owner only.

Parameters:
arbiter_prio, 1, fixed-priority winner on simultaneous requests: 1 = dmem first, 0 = imem first

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
imem_in  input  mem_in_type  fetch request (valid, fence, instr, addr, wdata, wstrb)
imem_out  output  mem_out_type  fetch response (ready, rdata)
dmem_in  input  mem_in_type  write-buffer request
dmem_out  output  mem_out_type  write-buffer response
mem_out  input  mem_out_type  shared memory response
mem_in  output  mem_in_type  shared memory request

Behaviour:
- Reset: rst is synchronous, active-low, on clk. rst=0 at a clock edge sets state=IDLE, clears both pending bits and hold registers, and sets last_grant=dmem. All outputs are combinational from state and are 0 during and after reset until a request arrives. A reset mid-transaction drops the outstanding request; the memory is reset by the same rst.
- Capture: x_in.mem_valid=1 sets pending_x and latches {fence, addr, wdata, wstrb} into hold_x. Valid is ignored while pending_x=1 or while x owns the bus, because the write buffer holds valid as a level until ready.
- Request candidates per port: req_x = pending_x | x_in.mem_valid. A same-cycle request uses the live inputs; otherwise the hold register is used.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If any req_x is set, pick a winner by arbiter_prio.
  - Drive mem_in from the winner: mem_valid=1, mem_instr=1 for imem and 0 for dmem, mem_fence from the winner.
  - Go to BUSY_winner and clear pending_winner. Zero added latency.
- BUSY_x:
  - mem_in.mem_valid=0; addr, wdata, wstrb, fence and instr stay driven from hold_x.
  - Wait for mem_out.mem_ready. On ready: x_out.mem_ready=1 and x_out.mem_rdata=mem_out.mem_rdata for exactly that cycle.
  - In the same cycle, if the other port has req, issue it immediately (back-to-back) and go to BUSY_other. Otherwise go to IDLE.
- Non-owner output is always ready=0, rdata=0.
- mem_out.mem_ready is sampled only in BUSY states. Memory ready arrives no earlier than one cycle after valid, and ready in IDLE is ignored.
- Fence: passed through as a normal dmem transaction with mem_fence=1 and wstrb=0; its ready is routed to dmem.
- Starvation: a ready in BUSY_D with a pending imem always hands off to imem, and vice versa, so neither port waits for more than one of the other's transactions.

Optional Feature:
MEM_ARBITER_RR_EN
- Defined: simultaneous requests in IDLE are granted to the port opposite last_grant (round-robin). last_grant updates on every grant. arbiter_prio is used only immediately after reset.
- Undefined: fixed priority per arbiter_prio. The last_grant register is not built.

Decomposition:
- mem_in_type and mem_out_type already live in package wires.
- The arbiter state enum (IDLE, BUSY_I, BUSY_D) and the reg_type struct are local to the module.
- One sub-module, mem_arbiter_hold (pending bit plus request hold register), is instantiated twice, once for imem and once for dmem.

Test Plan:
- Single fetch: imem valid addr=0x100 in IDLE -> same cycle mem_in.valid=1, instr=1, addr=0x100. Memory ready 2 cycles later with rdata=0xDEADBEEF -> imem_out.ready=1 and rdata=0xDEADBEEF for one cycle; dmem_out.ready stays 0.
- Collision: imem addr=0x200 and dmem store addr=0x80000000, wstrb=0xF, wdata=0x12345678 in the same cycle, arbiter_prio=1 -> store issued first. On its ready, fetch 0x200 is issued the same cycle with instr=1.
- Level-held valid: dmem valid held high for 4 cycles until ready -> exactly one mem_in.valid pulse, no duplicate transaction.
- Fence: dmem fence=1, wstrb=0 -> mem_in.fence=1, instr=0. Ready is routed to dmem_out only.
- Reset mid-op: rst=0 in BUSY_D -> next cycle state=IDLE, all outputs 0, pending cleared. A later fetch proceeds normally.
- RR (MEM_ARBITER_RR_EN): three back-to-back simultaneous imem+dmem pairs -> grants alternate D, I, D, I, D, I.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared memory-port types for the two-into-one memory arbiter.
//               Carries the request/response structs used on every port of
//               the arbiter (same layout as the bus types in the wires
//               package) and a small winner-selection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_xlen = 32;

    // Request as seen by the shared memory port
    typedef struct packed {
        logic                  mem_valid;
        logic                  mem_fence;
        logic                  mem_instr;
        logic [c_xlen-1:0]     mem_addr;
        logic [c_xlen-1:0]     mem_wdata;
        logic [c_xlen/8-1:0]   mem_wstrb;
    } mem_in_type;

    // Response from the shared memory port
    typedef struct packed {
        logic                  mem_ready;
        logic [c_xlen-1:0]     mem_rdata;
    } mem_out_type;

    // Winner selection when arbitrating in IDLE: returns 1 when dmem wins.
    // dmem wins if it is the only requester, or both request and dmem is
    // currently preferred.
    function automatic logic pick_dmem(
        input logic req_i,
        input logic req_d,
        input logic prefer_dmem
    );
        return req_d & (~req_i | prefer_dmem);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_hold
// Description : Per-requester pending bit plus request hold register.
//               A valid request is captured once (pending set, fields
//               latched); further valid cycles are ignored while the request
//               is pending or while this requester owns the bus, because the
//               requester holds valid as a level until it sees ready.
// Ports       : clk, rst   - clock, synchronous active-low reset
//               req_in     - live request from the requester
//               owner      - this requester currently owns the shared bus
//               grant      - the arbiter issues this requester this cycle
//               req        - request candidate (pending or live valid)
//               sel        - request to issue now (live if not pending)
//               hold       - latched request, drives the bus while busy
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_hold
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  req_in,
    input  logic        owner,
    input  logic        grant,
    output logic        req,
    output mem_in_type  sel,
    output mem_in_type  hold
);

    logic       pending_q;
    logic       pending_d;
    mem_in_type hold_q;
    mem_in_type hold_d;
    logic       w_capture;

    always_comb begin
        w_capture = req_in.mem_valid & ~pending_q & ~owner;
        pending_d = pending_q;
        hold_d    = hold_q;
        // Latch even when granted in the same cycle: the bus is driven from
        // the hold register for the rest of the transaction.
        if (w_capture) begin
            pending_d          = 1'b1;
            hold_d             = req_in;
            hold_d.mem_valid   = 1'b0;
            hold_d.mem_instr   = 1'b0;
        end
        if (grant) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            pending_q <= pending_d;
            hold_q    <= hold_d;
        end
    end

    assign req  = pending_q | req_in.mem_valid;
    assign sel  = pending_q ? hold_q : req_in;
    assign hold = hold_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-into-one memory arbiter between the instruction fetch
//               port (imem) and the write buffer (dmem) and one shared
//               memory port. One transaction in flight at a time; fetches are
//               tagged with mem_instr; ready/rdata go to the owner only.
//               A ready that completes one port's transaction immediately
//               issues the other port's waiting request (back-to-back).
// Parameters  : ARBITER_PRIO - winner on simultaneous requests
//                              (1 = dmem first, 0 = imem first)
// Config      : MEM_ARBITER_RR_EN - when defined, simultaneous requests are
//               granted opposite to the last grant (round-robin); the fixed
//               priority applies only to the first grant after reset.
// Ports       : clk       - clock
//               rst       - synchronous reset, active-low
//               imem_in   - fetch request        imem_out - fetch response
//               dmem_in   - write-buffer request dmem_out - its response
//               mem_out   - shared memory response
//               mem_in    - shared memory request
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic ARBITER_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    input  mem_out_type mem_out,
    output mem_in_type  mem_in
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    typedef struct packed {
        logic [1:0] state;
`ifdef MEM_ARBITER_RR_EN
        logic       last_dmem;  // last grant went to dmem
        logic       use_prio;   // no grant since reset yet
`endif
    } reg_type;

    reg_type    r_q;
    reg_type    r_d;

    logic       w_req_i;
    logic       w_req_d;
    mem_in_type w_sel_i;
    mem_in_type w_sel_d;
    mem_in_type w_hold_i;
    mem_in_type w_hold_d;
    logic       w_grant_i;
    logic       w_grant_d;
    logic       w_issue;
    logic       w_issue_dmem;
    logic       w_prefer_dmem;

    mem_arbiter_hold u_hold_i (
        .clk    (clk),
        .rst    (rst),
        .req_in (imem_in),
        .owner  (r_q.state == BUSY_I),
        .grant  (w_grant_i),
        .req    (w_req_i),
        .sel    (w_sel_i),
        .hold   (w_hold_i)
    );

    mem_arbiter_hold u_hold_d (
        .clk    (clk),
        .rst    (rst),
        .req_in (dmem_in),
        .owner  (r_q.state == BUSY_D),
        .grant  (w_grant_d),
        .req    (w_req_d),
        .sel    (w_sel_d),
        .hold   (w_hold_d)
    );

`ifdef MEM_ARBITER_RR_EN
    assign w_prefer_dmem = r_q.use_prio ? ARBITER_PRIO : ~r_q.last_dmem;
`else
    assign w_prefer_dmem = ARBITER_PRIO;
`endif

    always_comb begin
        r_d          = r_q;
        mem_in       = '0;
        imem_out     = '0;
        dmem_out     = '0;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_issue      = 1'b0;
        w_issue_dmem = 1'b0;

        case (r_q.state)
            IDLE: begin
                // Ready in IDLE is ignored; only requests matter here.
                if (w_req_i | w_req_d) begin
                    w_issue      = 1'b1;
                    w_issue_dmem = pick_dmem(w_req_i, w_req_d, w_prefer_dmem);
                end
            end
            BUSY_I: begin
                mem_in           = w_hold_i;
                mem_in.mem_valid = 1'b0;
                mem_in.mem_instr = 1'b1;
                if (mem_out.mem_ready) begin
                    imem_out = mem_out;
                    // Hand off to a waiting dmem so neither side starves
                    if (w_req_d) begin
                        w_issue      = 1'b1;
                        w_issue_dmem = 1'b1;
                    end else begin
                        r_d.state = IDLE;
                    end
                end
            end
            BUSY_D: begin
                mem_in           = w_hold_d;
                mem_in.mem_valid = 1'b0;
                mem_in.mem_instr = 1'b0;
                if (mem_out.mem_ready) begin
                    dmem_out = mem_out;
                    if (w_req_i) begin
                        w_issue      = 1'b1;
                        w_issue_dmem = 1'b0;
                    end else begin
                        r_d.state = IDLE;
                    end
                end
            end
            default: begin
                r_d.state = IDLE;
            end
        endcase

        // Issue overrides the busy drive of the completing transaction
        if (w_issue) begin
            if (w_issue_dmem) begin
                mem_in           = w_sel_d;
                mem_in.mem_instr = 1'b0;
                w_grant_d        = 1'b1;
                r_d.state        = BUSY_D;
            end else begin
                mem_in           = w_sel_i;
                mem_in.mem_instr = 1'b1;
                w_grant_i        = 1'b1;
                r_d.state        = BUSY_I;
            end
            mem_in.mem_valid = 1'b1;
`ifdef MEM_ARBITER_RR_EN
            r_d.last_dmem = w_issue_dmem;
            r_d.use_prio  = 1'b0;
`endif
        end

        // Outputs stay quiet for the whole reset cycle
        if (!rst) begin
            mem_in   = '0;
            imem_out = '0;
            dmem_out = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q.state     <= IDLE;
`ifdef MEM_ARBITER_RR_EN
            r_q.last_dmem <= 1'b1;
            r_q.use_prio  <= 1'b1;
`endif
        end else begin
            r_q <= r_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level
//               model (who is on the bus, which request each port has
//               waiting) predicts all outputs every cycle; directed sequences
//               add literal expectations, then randomized requesters and a
//               random-latency memory exercise the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam logic PRIO = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    mem_in_type  imem_in;
    mem_in_type  dmem_in;
    mem_in_type  mem_in;
    mem_out_type imem_out;
    mem_out_type dmem_out;
    mem_out_type mem_out;

    mem_arbiter #(.ARBITER_PRIO(PRIO)) dut (
        .clk      (clk),
        .rst      (rst),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .mem_out  (mem_out),
        .mem_in   (mem_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- transaction-level model ----------------
    int         m_owner = -1;      // -1 bus free, 0 imem, 1 dmem
    bit         m_wait [2];        // accepted, not yet on the bus
    mem_in_type m_saved[2];
    mem_in_type m_flight;          // transaction currently on the bus
    bit         m_fresh = 1'b1;    // no grant since reset
    int         m_last  = 1;       // port of last grant

    // ---------------- random agents ----------------
    bit         a_act[2];
    int         a_age[2];
    mem_in_type a_req[2];
    bit         mem_busy;
    int         mem_cnt;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic mem_in_type mk_req(input logic fence, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] wstrb);
        mem_in_type r;
        r           = '0;
        r.mem_valid = 1'b1;
        r.mem_fence = fence;
        r.mem_addr  = addr;
        r.mem_wdata = wdata;
        r.mem_wstrb = wstrb;
        return r;
    endfunction

    function automatic int both_winner();
`ifdef MEM_ARBITER_RR_EN
        if (!m_fresh) return 1 - m_last;
`endif
        return PRIO ? 1 : 0;
    endfunction

    // Predict this cycle's outputs from the current inputs, compare, then
    // advance the model to what the next clock edge produces.
    task automatic model_cycle();
        mem_in_type  e_mem;
        mem_out_type e_resp[2];
        mem_in_type  live[2];
        mem_in_type  cand[2];
        bit          req[2];
        int          issue;
        int          nxt;
        e_mem     = '0;
        e_resp[0] = '0;
        e_resp[1] = '0;
        live[0]   = imem_in;
        live[1]   = dmem_in;
        issue     = -1;
        nxt       = m_owner;
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                req[p]  = m_wait[p] | live[p].mem_valid;
                cand[p] = m_wait[p] ? m_saved[p] : live[p];
            end
            if (m_owner < 0) begin
                if (req[0] && req[1]) issue = both_winner();
                else if (req[0])      issue = 0;
                else if (req[1])      issue = 1;
            end else begin
                e_mem           = m_flight;
                e_mem.mem_valid = 1'b0;
                if (mem_out.mem_ready) begin
                    e_resp[m_owner] = mem_out;
                    if (req[1-m_owner]) issue = 1 - m_owner;
                    else                nxt   = -1;
                end
            end
            if (issue >= 0) begin
                m_flight           = cand[issue];
                m_flight.mem_valid = 1'b1;
                m_flight.mem_instr = (issue == 0);
                e_mem              = m_flight;
                nxt                = issue;
                m_last             = issue;
                m_fresh            = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (live[p].mem_valid && !m_wait[p] && m_owner != p) begin
                    m_wait[p]  = 1'b1;
                    m_saved[p] = live[p];
                end
            end
            if (issue >= 0) m_wait[issue] = 1'b0;
            m_owner = nxt;
        end else begin
            m_owner   = -1;
            m_wait[0] = 1'b0;
            m_wait[1] = 1'b0;
            m_fresh   = 1'b1;
            m_last    = 1;
        end
        chk("mem_in",   mem_in,   e_mem);
        chk("imem_out", imem_out, e_resp[0]);
        chk("dmem_out", dmem_out, e_resp[1]);
    endtask

    task automatic cyc_neg();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic cyc_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        imem_in = '0;
        dmem_in = '0;
        mem_out = '0;
    endtask

    task automatic drive_random();
        for (int p = 0; p < 2; p++) begin
            if (!a_act[p] && $urandom_range(0, 3) == 0) begin
                if (p == 0) begin
                    a_req[p] = mk_req(1'b0, $urandom & 32'hFFFF_FFFC, 32'h0, 4'h0);
                end else if ($urandom_range(0, 5) == 0) begin
                    a_req[p] = mk_req(1'b1, 32'h0, 32'h0, 4'h0);
                end else begin
                    a_req[p] = mk_req(1'b0, $urandom, $urandom, 4'($urandom_range(1, 15)));
                end
                a_act[p] = 1'b1;
                a_age[p] = 0;
            end
        end
        imem_in = a_act[0] ? a_req[0] : '0;
        dmem_in = a_act[1] ? a_req[1] : '0;
        mem_out = '0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_out.mem_ready = 1'b1;
                mem_out.mem_rdata = $urandom;
                mem_busy          = 1'b0;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            // stray ready while nothing is outstanding
            mem_out.mem_ready = 1'b1;
            mem_out.mem_rdata = $urandom;
        end
    endtask

    task automatic observe_random();
        if (imem_out.mem_ready) a_act[0] = 1'b0;
        if (dmem_out.mem_ready) a_act[1] = 1'b0;
        if (mem_in.mem_valid) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(1, 3);
        end
        for (int p = 0; p < 2; p++) begin
            if (a_act[p]) begin
                a_age[p]++;
                if (a_age[p] > 100) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stall port %0d: waited %0d cycles, required at most 100", p, a_age[p]);
                    a_act[p] = 1'b0;
                end
            end
        end
        if (!rst) begin
            a_act[0] = 1'b0;
            a_act[1] = 1'b0;
            mem_busy = 1'b0;
        end
    endtask

    int pulses;

    initial begin
        quiet();
        rst = 1'b0;
        repeat (2) begin
            cyc_neg();
            chk("reset_mem_in", mem_in, '0);
            cyc_pos();
        end
        rst = 1'b1;

        // Single fetch, memory ready two cycles after the request
        imem_in = mk_req(1'b0, 32'h100, 32'h0, 4'h0);
        cyc_neg();
        chk("fetch_valid", mem_in.mem_valid, 1);
        chk("fetch_instr", mem_in.mem_instr, 1);
        chk("fetch_addr",  mem_in.mem_addr, 32'h100);
        cyc_pos();
        cyc_neg();
        chk("fetch_wait_valid", mem_in.mem_valid, 0);
        cyc_pos();
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'hDEAD_BEEF};
        cyc_neg();
        chk("fetch_ready", imem_out.mem_ready, 1);
        chk("fetch_rdata", imem_out.mem_rdata, 32'hDEAD_BEEF);
        chk("fetch_dmem_quiet", dmem_out.mem_ready, 0);
        cyc_pos();
        quiet();
        cyc_neg();
        chk("fetch_ready_one_cycle", imem_out.mem_ready, 0);
        cyc_pos();

        // Collision: dmem wins, fetch follows back-to-back
        imem_in = mk_req(1'b0, 32'h200, 32'h0, 4'h0);
        dmem_in = mk_req(1'b0, 32'h8000_0000, 32'h1234_5678, 4'hF);
        cyc_neg();
        chk("coll_valid", mem_in.mem_valid, 1);
        chk("coll_addr",  mem_in.mem_addr, 32'h8000_0000);
        chk("coll_instr", mem_in.mem_instr, 0);
        chk("coll_wdata", mem_in.mem_wdata, 32'h1234_5678);
        chk("coll_wstrb", mem_in.mem_wstrb, 4'hF);
        cyc_pos();
        cyc_neg();
        chk("coll_busy_valid", mem_in.mem_valid, 0);
        cyc_pos();
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h0};
        cyc_neg();
        chk("coll_d_ready", dmem_out.mem_ready, 1);
        chk("coll_i_ready", imem_out.mem_ready, 0);
        chk("coll_b2b_valid", mem_in.mem_valid, 1);
        chk("coll_b2b_addr",  mem_in.mem_addr, 32'h200);
        chk("coll_b2b_instr", mem_in.mem_instr, 1);
        cyc_pos();
        dmem_in = '0;
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h0BAD_F00D};
        cyc_neg();
        chk("coll_fetch_rdata", imem_out.mem_rdata, 32'h0BAD_F00D);
        cyc_pos();
        quiet();
        cyc_neg();
        cyc_pos();

        // Level-held dmem valid: one bus transaction only
        pulses  = 0;
        dmem_in = mk_req(1'b0, 32'h40, 32'hCAFE_0001, 4'h3);
        for (int k = 0; k < 4; k++) begin
            mem_out = (k == 3) ? '{mem_ready: 1'b1, mem_rdata: 32'h5} : '0;
            cyc_neg();
            if (mem_in.mem_valid) pulses++;
            if (k == 3) chk("held_ready", dmem_out.mem_ready, 1);
            cyc_pos();
        end
        quiet();
        cyc_neg();
        if (mem_in.mem_valid) pulses++;
        cyc_pos();
        chk("held_pulses", pulses, 1);

        // Fence through dmem
        dmem_in = mk_req(1'b1, 32'h0, 32'h0, 4'h0);
        cyc_neg();
        chk("fence_fence", mem_in.mem_fence, 1);
        chk("fence_instr", mem_in.mem_instr, 0);
        cyc_pos();
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h77};
        cyc_neg();
        chk("fence_d_ready", dmem_out.mem_ready, 1);
        chk("fence_i_ready", imem_out.mem_ready, 0);
        cyc_pos();
        quiet();
        cyc_neg();
        cyc_pos();

        // Reset while BUSY_D with an imem request waiting
        dmem_in = mk_req(1'b0, 32'h500, 32'h1, 4'h1);
        cyc_neg();
        cyc_pos();
        imem_in = mk_req(1'b0, 32'h300, 32'h0, 4'h0);
        cyc_neg();
        cyc_pos();
        quiet();
        rst = 1'b0;
        cyc_neg();
        chk("rst_mem_in", mem_in, '0);
        cyc_pos();
        rst = 1'b1;
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h99};
        cyc_neg();
        chk("rst_pending_cleared", mem_in.mem_valid, 0);
        chk("rst_idle_ready_ignored", dmem_out.mem_ready, 0);
        cyc_pos();
        mem_out = '0;
        imem_in = mk_req(1'b0, 32'h400, 32'h0, 4'h0);
        cyc_neg();
        chk("post_rst_fetch_addr", mem_in.mem_addr, 32'h400);
        cyc_pos();
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h4444};
        cyc_neg();
        chk("post_rst_fetch_rdata", imem_out.mem_rdata, 32'h4444);
        cyc_pos();
        quiet();
        cyc_neg();
        cyc_pos();

        // Three simultaneous pairs: D, I each time
        for (int n = 0; n < 3; n++) begin
            imem_in = mk_req(1'b0, 32'h1000 + 32'(n), 32'h0, 4'h0);
            dmem_in = mk_req(1'b0, 32'h2000 + 32'(n), 32'hAB, 4'hF);
            cyc_neg();
            chk("pair_first_instr", mem_in.mem_instr, 0);
            cyc_pos();
            mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h1};
            cyc_neg();
            chk("pair_second_valid", mem_in.mem_valid, 1);
            chk("pair_second_instr", mem_in.mem_instr, 1);
            cyc_pos();
            dmem_in = '0;
            cyc_neg();
            chk("pair_i_ready", imem_out.mem_ready, 1);
            cyc_pos();
            quiet();
            cyc_neg();
            cyc_pos();
        end

        // Randomized traffic with occasional resets
        a_act[0] = 1'b0;
        a_act[1] = 1'b0;
        mem_busy = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            drive_random();
            cyc_neg();
            observe_random();
            cyc_pos();
        end
        rst = 1'b1;
        quiet();
        cyc_neg();
        cyc_pos();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
